// File: rtl/axi_arb_pkg.sv
// Shared encodings and field widths for the 2:1 AXI3 debug arbiter.
// Owner encoding doubles as the grant FSM state and the rd_owner/wr_owner debug value.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'b00,
    OWN_S0   = 2'b01,
    OWN_S1   = 2'b10
  } owner_e;

  localparam int LEN_W   = 4;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int LOCK_W  = 2;
  localparam int CACHE_W = 4;
  localparam int PROT_W  = 3;
  localparam int RESP_W  = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  // Lone requester always wins; a tie goes to s1 only when prefer_s1 is set.
  function automatic owner_e pick_owner(input logic req0, input logic req1,
                                        input logic prefer_s1);
    if (req0 && req1) return prefer_s1 ? OWN_S1 : OWN_S0;
    return req1 ? OWN_S1 : OWN_S0;
  endfunction

endpackage

// File: rtl/axi_arb_grant.sv
// Registered 2:1 grant FSM: idle -> owner on request, owner -> idle on xfer_done.
// ARB_DEBUG_PRIO_EN: s1 wins every tie and the round-robin pointer is removed.
module axi_arb_grant
  import axi_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req0,
  input  logic   req1,
  input  logic   xfer_done,
  output owner_e owner
);

`ifdef ARB_DEBUG_PRIO_EN

  // NOTE: state uses non-blocking assignments and an async reset in the
  // sensitivity list; blocking here would create ordering races between flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= OWN_IDLE;
    end else begin
      case (owner)
        OWN_IDLE: if (req0 || req1) owner <= pick_owner(req0, req1, 1'b1);
        default:  if (xfer_done)    owner <= OWN_IDLE;
      endcase
    end
  end

`else

  logic   prefer_s1;
  owner_e winner;

  assign winner = pick_owner(req0, req1, prefer_s1);

  // Pointer starts on s0 and flips to whichever port was not just granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= OWN_IDLE;
      prefer_s1 <= 1'b0;
    end else begin
      case (owner)
        OWN_IDLE: begin
          if (req0 || req1) begin
            owner     <= winner;
            prefer_s1 <= (winner == OWN_S0);
          end
        end
        default: if (xfer_done) owner <= OWN_IDLE;
      endcase
    end
  end

`endif

endmodule

// File: rtl/axi_debug_arbiter.sv
// 2:1 AXI3 arbiter: CPU (s0) and UART debug master (s1) share one slave port (m).
// Read and write paths are granted independently; ARB_DEBUG_PRIO_EN gives s1 fixed priority.
module axi_debug_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  // s0: CPU core
  input  logic [ID_W-1:0]    s0_arid,
  input  logic [ADDR_W-1:0]  s0_araddr,
  input  logic [LEN_W-1:0]   s0_arlen,
  input  logic [SIZE_W-1:0]  s0_arsize,
  input  logic [BURST_W-1:0] s0_arburst,
  input  logic [LOCK_W-1:0]  s0_arlock,
  input  logic [CACHE_W-1:0] s0_arcache,
  input  logic [PROT_W-1:0]  s0_arprot,
  input  logic               s0_arvalid,
  output logic               s0_arready,
  output logic [ID_W-1:0]    s0_rid,
  output logic [DATA_W-1:0]  s0_rdata,
  output logic [RESP_W-1:0]  s0_rresp,
  output logic               s0_rlast,
  output logic               s0_rvalid,
  input  logic               s0_rready,
  input  logic [ID_W-1:0]    s0_awid,
  input  logic [ADDR_W-1:0]  s0_awaddr,
  input  logic [LEN_W-1:0]   s0_awlen,
  input  logic [SIZE_W-1:0]  s0_awsize,
  input  logic [BURST_W-1:0] s0_awburst,
  input  logic [LOCK_W-1:0]  s0_awlock,
  input  logic [CACHE_W-1:0] s0_awcache,
  input  logic [PROT_W-1:0]  s0_awprot,
  input  logic               s0_awvalid,
  output logic               s0_awready,
  input  logic [ID_W-1:0]    s0_wid,
  input  logic [DATA_W-1:0]  s0_wdata,
  input  logic [DATA_W/8-1:0] s0_wstrb,
  input  logic               s0_wlast,
  input  logic               s0_wvalid,
  output logic               s0_wready,
  output logic [ID_W-1:0]    s0_bid,
  output logic [RESP_W-1:0]  s0_bresp,
  output logic               s0_bvalid,
  input  logic               s0_bready,
  // s1: UART debug-download master
  input  logic [ID_W-1:0]    s1_arid,
  input  logic [ADDR_W-1:0]  s1_araddr,
  input  logic [LEN_W-1:0]   s1_arlen,
  input  logic [SIZE_W-1:0]  s1_arsize,
  input  logic [BURST_W-1:0] s1_arburst,
  input  logic [LOCK_W-1:0]  s1_arlock,
  input  logic [CACHE_W-1:0] s1_arcache,
  input  logic [PROT_W-1:0]  s1_arprot,
  input  logic               s1_arvalid,
  output logic               s1_arready,
  output logic [ID_W-1:0]    s1_rid,
  output logic [DATA_W-1:0]  s1_rdata,
  output logic [RESP_W-1:0]  s1_rresp,
  output logic               s1_rlast,
  output logic               s1_rvalid,
  input  logic               s1_rready,
  input  logic [ID_W-1:0]    s1_awid,
  input  logic [ADDR_W-1:0]  s1_awaddr,
  input  logic [LEN_W-1:0]   s1_awlen,
  input  logic [SIZE_W-1:0]  s1_awsize,
  input  logic [BURST_W-1:0] s1_awburst,
  input  logic [LOCK_W-1:0]  s1_awlock,
  input  logic [CACHE_W-1:0] s1_awcache,
  input  logic [PROT_W-1:0]  s1_awprot,
  input  logic               s1_awvalid,
  output logic               s1_awready,
  input  logic [ID_W-1:0]    s1_wid,
  input  logic [DATA_W-1:0]  s1_wdata,
  input  logic [DATA_W/8-1:0] s1_wstrb,
  input  logic               s1_wlast,
  input  logic               s1_wvalid,
  output logic               s1_wready,
  output logic [ID_W-1:0]    s1_bid,
  output logic [RESP_W-1:0]  s1_bresp,
  output logic               s1_bvalid,
  input  logic               s1_bready,
  // m: towards crossbar / memory controller
  output logic [ID_W-1:0]    m_arid,
  output logic [ADDR_W-1:0]  m_araddr,
  output logic [LEN_W-1:0]   m_arlen,
  output logic [SIZE_W-1:0]  m_arsize,
  output logic [BURST_W-1:0] m_arburst,
  output logic [LOCK_W-1:0]  m_arlock,
  output logic [CACHE_W-1:0] m_arcache,
  output logic [PROT_W-1:0]  m_arprot,
  output logic               m_arvalid,
  input  logic               m_arready,
  input  logic [ID_W-1:0]    m_rid,
  input  logic [DATA_W-1:0]  m_rdata,
  input  logic [RESP_W-1:0]  m_rresp,
  input  logic               m_rlast,
  input  logic               m_rvalid,
  output logic               m_rready,
  output logic [ID_W-1:0]    m_awid,
  output logic [ADDR_W-1:0]  m_awaddr,
  output logic [LEN_W-1:0]   m_awlen,
  output logic [SIZE_W-1:0]  m_awsize,
  output logic [BURST_W-1:0] m_awburst,
  output logic [LOCK_W-1:0]  m_awlock,
  output logic [CACHE_W-1:0] m_awcache,
  output logic [PROT_W-1:0]  m_awprot,
  output logic               m_awvalid,
  input  logic               m_awready,
  output logic [ID_W-1:0]    m_wid,
  output logic [DATA_W-1:0]  m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic               m_wlast,
  output logic               m_wvalid,
  input  logic               m_wready,
  input  logic [ID_W-1:0]    m_bid,
  input  logic [RESP_W-1:0]  m_bresp,
  input  logic               m_bvalid,
  output logic               m_bready,
  // debug
  output logic [1:0]         rd_owner,
  output logic [1:0]         wr_owner
);

  owner_e rd_own, wr_own;
  logic   rd_s0, rd_s1, wr_s0, wr_s1;
  logic   ar_done, aw_done, w_done;
  logic   rd_release, wr_release;

  assign rd_s0 = (rd_own == OWN_S0);
  assign rd_s1 = (rd_own == OWN_S1);
  assign wr_s0 = (wr_own == OWN_S0);
  assign wr_s1 = (wr_own == OWN_S1);

  assign rd_owner = rd_own;
  assign wr_owner = wr_own;

  // m_rready/m_bready are zero while idle, so release can only fire for an owner.
  assign rd_release = m_rvalid & m_rready & m_rlast;
  assign wr_release = m_bvalid & m_bready;

  axi_arb_grant u_rd_grant (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (s0_arvalid),
    .req1      (s1_arvalid),
    .xfer_done (rd_release),
    .owner     (rd_own)
  );

  // W-only traffic is not a request; the write grant is keyed on AW.
  axi_arb_grant u_wr_grant (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (s0_awvalid),
    .req1      (s1_awvalid),
    .xfer_done (wr_release),
    .owner     (wr_own)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (rd_release)                   ar_done <= 1'b0;
      else if (m_arvalid && m_arready)  ar_done <= 1'b1;

      if (wr_release) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (m_awvalid && m_awready)          aw_done <= 1'b1;
        if (m_wvalid && m_wready && m_wlast) w_done  <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- read path
  // NOTE: every output of a combinational block gets a default first so that
  // the idle branch cannot leave anything unassigned and infer a latch.
  always_comb begin
    m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
    m_arlock = '0; m_arcache = '0; m_arprot = '0; m_arvalid = 1'b0;
    if (rd_s0) begin
      m_arid = s0_arid; m_araddr = s0_araddr; m_arlen = s0_arlen;
      m_arsize = s0_arsize; m_arburst = s0_arburst; m_arlock = s0_arlock;
      m_arcache = s0_arcache; m_arprot = s0_arprot;
      m_arvalid = s0_arvalid & ~ar_done;
    end else if (rd_s1) begin
      m_arid = s1_arid; m_araddr = s1_araddr; m_arlen = s1_arlen;
      m_arsize = s1_arsize; m_arburst = s1_arburst; m_arlock = s1_arlock;
      m_arcache = s1_arcache; m_arprot = s1_arprot;
      m_arvalid = s1_arvalid & ~ar_done;
    end
  end

  assign s0_arready = rd_s0 & ~ar_done & m_arready;
  assign s1_arready = rd_s1 & ~ar_done & m_arready;
  assign m_rready   = (rd_s0 & s0_rready) | (rd_s1 & s1_rready);

  always_comb begin
    s0_rid = '0; s0_rdata = '0; s0_rresp = '0; s0_rlast = 1'b0; s0_rvalid = 1'b0;
    s1_rid = '0; s1_rdata = '0; s1_rresp = '0; s1_rlast = 1'b0; s1_rvalid = 1'b0;
    if (rd_s0) begin
      s0_rid = m_rid; s0_rdata = m_rdata; s0_rresp = m_rresp;
      s0_rlast = m_rlast; s0_rvalid = m_rvalid;
    end else if (rd_s1) begin
      s1_rid = m_rid; s1_rdata = m_rdata; s1_rresp = m_rresp;
      s1_rlast = m_rlast; s1_rvalid = m_rvalid;
    end
  end

  // --------------------------------------------------------------- write path
  always_comb begin
    m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0;
    m_awlock = '0; m_awcache = '0; m_awprot = '0; m_awvalid = 1'b0;
    m_wid = '0; m_wdata = '0; m_wstrb = '0; m_wlast = 1'b0; m_wvalid = 1'b0;
    if (wr_s0) begin
      m_awid = s0_awid; m_awaddr = s0_awaddr; m_awlen = s0_awlen;
      m_awsize = s0_awsize; m_awburst = s0_awburst; m_awlock = s0_awlock;
      m_awcache = s0_awcache; m_awprot = s0_awprot;
      m_awvalid = s0_awvalid & ~aw_done;
      m_wid = s0_wid; m_wdata = s0_wdata; m_wstrb = s0_wstrb; m_wlast = s0_wlast;
      m_wvalid = s0_wvalid & ~w_done;
    end else if (wr_s1) begin
      m_awid = s1_awid; m_awaddr = s1_awaddr; m_awlen = s1_awlen;
      m_awsize = s1_awsize; m_awburst = s1_awburst; m_awlock = s1_awlock;
      m_awcache = s1_awcache; m_awprot = s1_awprot;
      m_awvalid = s1_awvalid & ~aw_done;
      m_wid = s1_wid; m_wdata = s1_wdata; m_wstrb = s1_wstrb; m_wlast = s1_wlast;
      m_wvalid = s1_wvalid & ~w_done;
    end
  end

  assign s0_awready = wr_s0 & ~aw_done & m_awready;
  assign s1_awready = wr_s1 & ~aw_done & m_awready;
  assign s0_wready  = wr_s0 & ~w_done & m_wready;
  assign s1_wready  = wr_s1 & ~w_done & m_wready;
  assign m_bready   = (wr_s0 & s0_bready) | (wr_s1 & s1_bready);

  // B is routed purely by grant state; bresp errors pass through untouched.
  always_comb begin
    s0_bid = '0; s0_bresp = '0; s0_bvalid = 1'b0;
    s1_bid = '0; s1_bresp = '0; s1_bvalid = 1'b0;
    if (wr_s0) begin
      s0_bid = m_bid; s0_bresp = m_bresp; s0_bvalid = m_bvalid;
    end else if (wr_s1) begin
      s1_bid = m_bid; s1_bresp = m_bresp; s1_bvalid = m_bvalid;
    end
  end

endmodule

// File: tb/tb_axi_debug_arbiter.sv
// Directed bench for axi_debug_arbiter; the bench itself acts as the downstream slave.
// Build with +define+ARB_DEBUG_PRIO_EN to check the fixed-priority variant.
module tb_axi_debug_arbiter;

  logic        clk, rst_n;
  logic [3:0]  s0_arid, s1_arid, m_arid, s0_awid, s1_awid, m_awid;
  logic [31:0] s0_araddr, s1_araddr, m_araddr, s0_awaddr, s1_awaddr, m_awaddr;
  logic [3:0]  s0_arlen, s1_arlen, m_arlen, s0_awlen, s1_awlen, m_awlen;
  logic [2:0]  s0_arsize, s1_arsize, m_arsize, s0_awsize, s1_awsize, m_awsize;
  logic [1:0]  s0_arburst, s1_arburst, m_arburst, s0_awburst, s1_awburst, m_awburst;
  logic [1:0]  s0_arlock, s1_arlock, m_arlock, s0_awlock, s1_awlock, m_awlock;
  logic [3:0]  s0_arcache, s1_arcache, m_arcache, s0_awcache, s1_awcache, m_awcache;
  logic [2:0]  s0_arprot, s1_arprot, m_arprot, s0_awprot, s1_awprot, m_awprot;
  logic        s0_arvalid, s1_arvalid, m_arvalid, s0_arready, s1_arready, m_arready;
  logic        s0_awvalid, s1_awvalid, m_awvalid, s0_awready, s1_awready, m_awready;
  logic [3:0]  s0_rid, s1_rid, m_rid, s0_wid, s1_wid, m_wid, s0_bid, s1_bid, m_bid;
  logic [31:0] s0_rdata, s1_rdata, m_rdata, s0_wdata, s1_wdata, m_wdata;
  logic [3:0]  s0_wstrb, s1_wstrb, m_wstrb;
  logic [1:0]  s0_rresp, s1_rresp, m_rresp, s0_bresp, s1_bresp, m_bresp;
  logic        s0_rlast, s1_rlast, m_rlast, s0_wlast, s1_wlast, m_wlast;
  logic        s0_rvalid, s1_rvalid, m_rvalid, s0_rready, s1_rready, m_rready;
  logic        s0_wvalid, s1_wvalid, m_wvalid, s0_wready, s1_wready, m_wready;
  logic        s0_bvalid, s1_bvalid, m_bvalid, s0_bready, s1_bready, m_bready;
  logic [1:0]  rd_owner, wr_owner;

  int n_checks = 0;
  int n_fail   = 0;
  int w_hs     = 0;   // W handshakes seen on the slave side
  int b1_hs    = 0;   // B handshakes delivered to s1

  axi_debug_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
    .s0_arburst(s0_arburst), .s0_arlock(s0_arlock), .s0_arcache(s0_arcache),
    .s0_arprot(s0_arprot), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s0_awid(s0_awid), .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awsize(s0_awsize),
    .s0_awburst(s0_awburst), .s0_awlock(s0_awlock), .s0_awcache(s0_awcache),
    .s0_awprot(s0_awprot), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
    .s0_wid(s0_wid), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast),
    .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
    .s0_bid(s0_bid), .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
    .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
    .s1_arburst(s1_arburst), .s1_arlock(s1_arlock), .s1_arcache(s1_arcache),
    .s1_arprot(s1_arprot), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rid(s1_rid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .s1_awid(s1_awid), .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awsize(s1_awsize),
    .s1_awburst(s1_awburst), .s1_awlock(s1_awlock), .s1_awcache(s1_awcache),
    .s1_awprot(s1_awprot), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
    .s1_wid(s1_wid), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast),
    .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
    .s1_bid(s1_bid), .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache),
    .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache),
    .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .rd_owner(rd_owner), .wr_owner(wr_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_wvalid && m_wready)   w_hs  <= w_hs + 1;
    if (s1_bvalid && s1_bready) b1_hs <= b1_hs + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 2 ns after the next rising edge; all driving happens there.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Called while a single-beat read is granted with m_arvalid up: complete it.
  task automatic finish_read(input logic to_s1);
    tick();
    if (to_s1) s1_arvalid = 1'b0; else s0_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b1;
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
  endtask

  logic first_s1;
  int   w_base, b_base;

  initial begin
    {s0_arid, s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_arlock, s0_arcache, s0_arprot} = '0;
    {s1_arid, s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_arlock, s1_arcache, s1_arprot} = '0;
    {s0_awid, s0_awaddr, s0_awlen, s0_awsize, s0_awburst, s0_awlock, s0_awcache, s0_awprot} = '0;
    {s1_awid, s1_awaddr, s1_awlen, s1_awsize, s1_awburst, s1_awlock, s1_awcache, s1_awprot} = '0;
    {s0_wid, s0_wdata, s0_wstrb, s0_wlast, s1_wid, s1_wdata, s1_wstrb, s1_wlast} = '0;
    {m_rid, m_rdata, m_rresp, m_rlast, m_bid, m_bresp} = '0;
    s0_rready = 1'b1; s1_rready = 1'b1; s0_bready = 1'b1; s1_bready = 1'b1;
    m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
    // Requests and responses pending during reset must not leak through.
    s0_arvalid = 1'b1; s1_awvalid = 1'b1; s0_wvalid = 1'b1; s1_wvalid = 1'b0;
    s1_arvalid = 1'b0; s0_awvalid = 1'b0; m_rvalid = 1'b1; m_bvalid = 1'b1;
    rst_n = 1'b0;

    #13;
    check("rst_rd_owner",  rd_owner,   2'b00);
    check("rst_wr_owner",  wr_owner,   2'b00);
    check("rst_m_arvalid", m_arvalid,  1'b0);
    check("rst_m_awvalid", m_awvalid,  1'b0);
    check("rst_m_wvalid",  m_wvalid,   1'b0);
    check("rst_s0_arrdy",  s0_arready, 1'b0);
    check("rst_s0_rvalid", s0_rvalid,  1'b0);
    check("rst_s1_bvalid", s1_bvalid,  1'b0);
    check("rst_m_rready",  m_rready,   1'b0);
    s0_arvalid = 1'b0; s1_awvalid = 1'b0; s0_wvalid = 1'b0; m_rvalid = 1'b0; m_bvalid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // ---- 2: simultaneous AR from reset
`ifdef ARB_DEBUG_PRIO_EN
    first_s1 = 1'b1;
`else
    first_s1 = 1'b0;
`endif
    s0_arvalid = 1'b1; s0_arid = 4'd1; s0_araddr = 32'h0000_0100;
    s1_arvalid = 1'b1; s1_arid = 4'd3; s1_araddr = 32'h0000_0200;
    #1;
    check("t2_no_comb_grant", m_arvalid, 1'b0);
    tick();
    check("t2_first_owner", rd_owner, first_s1 ? 2'b10 : 2'b01);
    check("t2_first_addr",  m_araddr, first_s1 ? 32'h200 : 32'h100);
    check("t2_first_arid",  m_arid,   first_s1 ? 4'd3 : 4'd1);
    check("t2_loser_arrdy", first_s1 ? s0_arready : s1_arready, 1'b0);
    tick();
    if (first_s1) s1_arvalid = 1'b0; else s0_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = first_s1 ? 4'd3 : 4'd1; m_rdata = 32'hA0;
    #1;
    check("t2_first_rdata",  first_s1 ? s1_rdata : s0_rdata, 32'hA0);
    check("t2_loser_rvalid", first_s1 ? s0_rvalid : s1_rvalid, 1'b0);
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    check("t2_idle_gap", rd_owner, 2'b00);
    check("t2_idle_arv", m_arvalid, 1'b0);
    tick();
    check("t2_second_owner", rd_owner, first_s1 ? 2'b01 : 2'b10);
    check("t2_second_addr",  m_araddr, first_s1 ? 32'h100 : 32'h200);
    tick();
    if (first_s1) s0_arvalid = 1'b0; else s1_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = first_s1 ? 4'd1 : 4'd3; m_rresp = 2'b10;
    #1;
    check("t2_slverr_pass", first_s1 ? s0_rresp : s1_rresp, 2'b10);
    check("t2_second_rid",  first_s1 ? s0_rid : s1_rid, first_s1 ? 4'd1 : 4'd3);
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
    check("t2_done", rd_owner, 2'b00);

    // ---- 1: s1 single write, s0 idle
    w_base = w_hs; b_base = b1_hs;
    s1_awvalid = 1'b1; s1_awid = 4'd2; s1_awaddr = 32'h1C00_0000;
    s1_wvalid = 1'b1; s1_wid = 4'd2; s1_wdata = 32'hDEAD_BEEF; s1_wstrb = 4'hF; s1_wlast = 1'b1;
    #1;
    check("t1_aw_latency0", m_awvalid, 1'b0);
    tick();
    check("t1_wr_owner",  wr_owner,  2'b10);
    check("t1_m_awvalid", m_awvalid, 1'b1);
    check("t1_m_awaddr",  m_awaddr,  32'h1C00_0000);
    check("t1_m_wdata",   m_wdata,   32'hDEAD_BEEF);
    check("t1_m_wstrb",   m_wstrb,   4'hF);
    tick();
    #1;
    check("t1_aw_once",   m_awvalid,  1'b0);
    check("t1_awrdy_off", s1_awready, 1'b0);
    s1_awvalid = 1'b0; s1_wvalid = 1'b0;
    m_bvalid = 1'b1; m_bid = 4'd2; m_bresp = 2'b00;
    #1;
    check("t1_s1_bvalid", s1_bvalid, 1'b1);
    check("t1_s1_bid",    s1_bid,    4'd2);
    check("t1_s0_bvalid", s0_bvalid, 1'b0);
    tick();
    m_bvalid = 1'b0;
    check("t1_wr_idle", wr_owner, 2'b00);
    check("t1_w_count", w_hs - w_base, 1);
    check("t1_b_count", b1_hs - b_base, 1);

    // ---- 3: s0 4-beat read, s1 requests mid-burst
    s0_arvalid = 1'b1; s0_arid = 4'd5; s0_araddr = 32'h0000_0300; s0_arlen = 4'd3;
    tick();
    check("t3_m_arlen", m_arlen, 4'd3);
    tick();
    s0_arvalid = 1'b0;
    s1_arvalid = 1'b1; s1_arid = 4'd6; s1_araddr = 32'h0000_0400; s1_arlen = 4'd0;
    m_rvalid = 1'b1; m_rlast = 1'b0; m_rid = 4'd5; m_rdata = 32'hC0;
    #1;
    check("t3_beat0_data", s0_rdata, 32'hC0);
    check("t3_s1_blocked0", s1_arready, 1'b0);
    for (int b = 1; b < 4; b++) begin
      tick();
      m_rdata = 32'hC0 + b;
      m_rlast = (b == 3);
      #1;
      check("t3_s1_blocked", s1_arready, 1'b0);
      check("t3_no_m_arv",   m_arvalid,  1'b0);
      check("t3_beat_rlast", s0_rlast,   (b == 3));
    end
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    check("t3_idle_gap", rd_owner, 2'b00);
    tick();
    check("t3_s1_owner", rd_owner,   2'b10);
    check("t3_s1_arv",   m_arvalid,  1'b1);
    check("t3_s1_addr",  m_araddr,   32'h400);
    check("t3_s1_arrdy", s1_arready, 1'b1);
    finish_read(1'b1);
    check("t3_done", rd_owner, 2'b00);

    // ---- 4: s1 W two cycles before AW
    w_base = w_hs; b_base = b1_hs;
    s1_wvalid = 1'b1; s1_wid = 4'd4; s1_wdata = 32'h1234_5678; s1_wstrb = 4'hF; s1_wlast = 1'b1;
    tick();
    tick();
    check("t4_no_grant_w", wr_owner,  2'b00);
    check("t4_no_m_wv",    m_wvalid,  1'b0);
    check("t4_no_wready",  s1_wready, 1'b0);
    s1_awvalid = 1'b1; s1_awid = 4'd4; s1_awaddr = 32'h1C00_0010;
    tick();
    check("t4_owner",   wr_owner, 2'b10);
    check("t4_m_wdata", m_wdata,  32'h1234_5678);
    check("t4_m_wv",    m_wvalid, 1'b1);
    tick();
    s1_awvalid = 1'b0;
    #1;
    check("t4_w_once", m_wvalid, 1'b0);
    s1_wvalid = 1'b0;
    m_bvalid = 1'b1; m_bid = 4'd4;
    tick();
    m_bvalid = 1'b0;
    tick();
    check("t4_w_count", w_hs - w_base, 1);
    check("t4_b_count", b1_hs - b_base, 1);
    check("t4_idle",    wr_owner, 2'b00);

    // ---- 5: s0 read concurrent with s1 write
    s0_arvalid = 1'b1; s0_arid = 4'd7; s0_araddr = 32'h0000_0500; s0_arlen = 4'd0;
    s1_awvalid = 1'b1; s1_awaddr = 32'h1C00_0020; s1_wvalid = 1'b1; s1_wdata = 32'h55;
    tick();
    check("t5_rd_owner", rd_owner, 2'b01);
    check("t5_wr_owner", wr_owner, 2'b10);
    tick();
    s0_arvalid = 1'b0; s1_awvalid = 1'b0; s1_wvalid = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = 4'd7;
    m_bvalid = 1'b1; m_bid = 4'd2; m_bresp = 2'b10;
    #1;
    check("t5_s0_rvalid", s0_rvalid, 1'b1);
    check("t5_s1_bvalid", s1_bvalid, 1'b1);
    check("t5_s1_bresp",  s1_bresp,  2'b10);
    check("t5_s0_bvalid", s0_bvalid, 1'b0);
    check("t5_s1_rvalid", s1_rvalid, 1'b0);
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    check("t5_rd_idle", rd_owner, 2'b00);
    check("t5_wr_idle", wr_owner, 2'b00);

    // ---- write-path tie: s1 was granted last, so round-robin favours s0
    s0_awvalid = 1'b1; s1_awvalid = 1'b1;
    tick();
`ifdef ARB_DEBUG_PRIO_EN
    check("tw_tie_owner", wr_owner, 2'b10);
`else
    check("tw_tie_owner", wr_owner, 2'b01);
`endif
    tick();
    if (wr_owner == 2'b10) s1_awvalid = 1'b0; else s0_awvalid = 1'b0;
    m_bvalid = 1'b1;
    tick();
    m_bvalid = 1'b0;
    tick();
`ifdef ARB_DEBUG_PRIO_EN
    check("tw_tie_second", wr_owner, 2'b01);
`else
    check("tw_tie_second", wr_owner, 2'b10);
`endif
    tick();
    s0_awvalid = 1'b0; s1_awvalid = 1'b0;
    m_bvalid = 1'b1;
    tick();
    m_bvalid = 1'b0;
    check("tw_idle", wr_owner, 2'b00);

    // ---- 6: reset during beat 2 of an s0 burst
    s0_arvalid = 1'b1; s0_arid = 4'd8; s0_araddr = 32'h0000_0600; s0_arlen = 4'd3;
    tick();
    tick();
    s0_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b0; m_rid = 4'd8; m_rdata = 32'hE0;
    tick();
    m_rdata = 32'hE1;
    tick();
    m_rdata = 32'hE2;
    s1_arvalid = 1'b1; s1_arid = 4'd9; s1_araddr = 32'h0000_0700; s1_arlen = 4'd0;
    #1;
    check("t6_pre_rvalid", s0_rvalid, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_rvalid", s0_rvalid, 1'b0);
    check("t6_rst_rready", m_rready,  1'b0);
    check("t6_rst_owner",  rd_owner,  2'b00);
    check("t6_rst_arv",    m_arvalid, 1'b0);
    m_rvalid = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    check("t6_new_owner", rd_owner, 2'b10);
    check("t6_new_addr",  m_araddr, 32'h700);
    finish_read(1'b1);
    check("t6_done", rd_owner, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
